fir_sched_ctrl: RTL and testbench

- Sequencer and coefficient store for the 29-tap symmetric complex FIR datapath (5 pre-adders, 5 complex multipliers, 3 phases per output sample).
- Decides when a sample is pulled from the input FIFO and when the sample shift register advances.
- Supplies per-lane coefficients for each phase and generates the accumulator and PushOut controls, aligned to the datapath pipeline latency.
- Holds a double-buffered (shadow/active) coefficient bank so coefficient updates never corrupt an output sample in flight.

---
 rtl/fir_pkg.sv | 33 +++
 rtl/fir_coef_bank.sv | 63 ++++++
 rtl/fir_sched_ctrl.sv | 95 +++++++++
 tb/tb_fir_sched_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants, phase encoding and coefficient types for the symmetric
// complex FIR sequencer.
package fir_pkg;

  localparam int unsigned NLANE  = 5;
  localparam int unsigned NTAP_U = 15;
  localparam int unsigned CW     = 27;
  localparam int unsigned LAT    = 4;
  localparam int unsigned TAPW   = 4;

  typedef enum logic [1:0] {
    PH0  = 2'd0,
    PH1  = 2'd1,
    PH2  = 2'd2,
    IDLE = 2'd3
  } phase_e;

  typedef struct packed {
    logic signed [CW-1:0] i;
    logic signed [CW-1:0] q;
  } coef_t;

  typedef struct packed {
    logic   valid;
    phase_e phase;
  } pipe_t;

  // Unique tap feeding a lane in a given phase; meaningless for IDLE.
  function automatic logic [TAPW-1:0] tap_of(input phase_e ph, input int unsigned lane);
    return TAPW'(ph) * TAPW'(NLANE) + TAPW'(lane);
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Double-buffered coefficient store: writes land in shadow, a swap copies
// shadow to active when dirty, and the five lanes read active by phase.
module fir_coef_bank
  import fir_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [4:0]          wr_addr,
  input  coef_t               wr_data,
  input  logic                swap,
  input  phase_e              rd_phase,
  output logic [NLANE*CW-1:0] lane_i,
  output logic [NLANE*CW-1:0] lane_q
);

  coef_t shadow_q [NTAP_U];
  coef_t shadow_d [NTAP_U];
  coef_t active_q [NTAP_U];
  coef_t active_d [NTAP_U];
  logic  dirty_q, dirty_d;
  logic  wr_ok;

  // Swap copies the pre-write shadow; a coincident write keeps dirty set.
  always_comb begin
    wr_ok    = wr_en && (wr_addr < 5'(NTAP_U));
    shadow_d = shadow_q;
    active_d = active_q;
    dirty_d  = dirty_q;
    if (swap && dirty_q) begin
      active_d = shadow_q;
      dirty_d  = 1'b0;
    end
    if (wr_ok) begin
      shadow_d[wr_addr[3:0]] = wr_data;
      dirty_d                = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '{default: '0};
      active_q <= '{default: '0};
      dirty_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      dirty_q  <= dirty_d;
    end
  end

  always_comb begin
    lane_i = '0;
    lane_q = '0;
    if (rd_phase != IDLE) begin
      for (int unsigned k = 0; k < NLANE; k++) begin
        lane_i[k*CW +: CW] = active_q[tap_of(rd_phase, k)].i;
        lane_q[k*CW +: CW] = active_q[tap_of(rd_phase, k)].q;
      end
    end
  end

endmodule

// File: rtl/fir_sched_ctrl.sv
// Phase sequencer for the 29-tap symmetric complex FIR: FIFO/shift control,
// per-phase lane coefficients, and latency-aligned accumulator/output strobes.
module fir_sched_ctrl
  import fir_pkg::*;
(
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       FifoEmpty,
  output logic                       FifoRd,
  output logic                       ShiftEn,
  output logic [1:0]                 Phase,
  output logic                       CenterSel,
  input  logic                       PushCoef,
  input  logic [4:0]                 CoefAddr,
  input  logic signed [CW-1:0]       CoefI,
  input  logic signed [CW-1:0]       CoefQ,
  output logic [NLANE*CW-1:0]        LaneCoefI,
  output logic [NLANE*CW-1:0]        LaneCoefQ,
  output logic                       AccLoad,
  output logic                       AccEn,
  output logic                       PushOut
);

  phase_e state_q, state_d;
  pipe_t  pipe_q [LAT];
  pipe_t  pipe_d [LAT];
  logic   push_q, push_d;
  coef_t  wr_coef;
  logic   swap;

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!FifoEmpty) state_d = PH0;
      PH0:     state_d = PH1;
      PH1:     state_d = PH2;
      PH2:     state_d = FifoEmpty ? IDLE : PH0;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    FifoRd    = (state_q == PH0);
    ShiftEn   = (state_q == PH0);
    Phase     = state_q;
    CenterSel = (state_q == PH2);
    AccLoad   = pipe_q[LAT-1].valid && (pipe_q[LAT-1].phase == PH0);
    AccEn     = pipe_q[LAT-1].valid && (pipe_q[LAT-1].phase != PH0);
    PushOut   = push_q;
  end

  always_comb begin
    pipe_d[0].valid = (state_q != IDLE);
    pipe_d[0].phase = state_q;
    for (int unsigned s = 1; s < LAT; s++) begin
      pipe_d[s] = pipe_q[s-1];
    end
    push_d = pipe_q[LAT-1].valid && (pipe_q[LAT-1].phase == PH2);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pipe_q <= '{default: '0};
      push_q <= 1'b0;
    end else begin
      pipe_q <= pipe_d;
      push_q <= push_d;
    end
  end

  // Every entry into PH0 is a sample boundary, so that is where banks swap.
  always_comb begin
    wr_coef.i = CoefI;
    wr_coef.q = CoefQ;
    swap      = (state_d == PH0);
  end

  fir_coef_bank u_bank (
    .clk      (Clk),
    .rst      (Reset),
    .wr_en    (PushCoef),
    .wr_addr  (CoefAddr),
    .wr_data  (wr_coef),
    .swap     (swap),
    .rd_phase (state_q),
    .lane_i   (LaneCoefI),
    .lane_q   (LaneCoefQ)
  );

endmodule

// File: tb/tb_fir_sched_ctrl.sv
// Self-checking bench for fir_sched_ctrl: per-sample expectations are queued
// when stimulus is driven and checked cycle by cycle by a scoreboard monitor.
module tb_fir_sched_ctrl;
  import fir_pkg::*;

  logic                 Clk = 1'b0;
  logic                 Reset, FifoEmpty, FifoRd, ShiftEn, CenterSel;
  logic                 PushCoef, AccLoad, AccEn, PushOut;
  logic [1:0]           Phase;
  logic [4:0]           CoefAddr;
  logic signed [CW-1:0] CoefI, CoefQ;
  logic [NLANE*CW-1:0]  LaneCoefI, LaneCoefQ;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int                  cyc;
    logic [1:0]          ph;
    logic [NLANE*CW-1:0] li;
    logic [NLANE*CW-1:0] lq;
  } issue_t;

  typedef struct {
    int   cyc;
    logic ld;
    logic en;
  } acc_t;

  issue_t exp_issue[$];
  acc_t   exp_acc[$];
  int     exp_push[$];

  logic signed [CW-1:0] sh_i [NTAP_U];
  logic signed [CW-1:0] sh_q [NTAP_U];
  logic signed [CW-1:0] ac_i [NTAP_U];
  logic signed [CW-1:0] ac_q [NTAP_U];
  bit                   dirty;

  fir_sched_ctrl dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .FifoEmpty (FifoEmpty),
    .FifoRd    (FifoRd),
    .ShiftEn   (ShiftEn),
    .Phase     (Phase),
    .CenterSel (CenterSel),
    .PushCoef  (PushCoef),
    .CoefAddr  (CoefAddr),
    .CoefI     (CoefI),
    .CoefQ     (CoefQ),
    .LaneCoefI (LaneCoefI),
    .LaneCoefQ (LaneCoefQ),
    .AccLoad   (AccLoad),
    .AccEn     (AccEn),
    .PushOut   (PushOut)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  task automatic m_clear();
    for (int t = 0; t < 15; t++) begin
      sh_i[t] = '0; sh_q[t] = '0; ac_i[t] = '0; ac_q[t] = '0;
    end
    dirty = 1'b0;
  endtask

  task automatic m_swap();
    if (dirty) begin
      ac_i  = sh_i;
      ac_q  = sh_q;
      dirty = 1'b0;
    end
  endtask

  task automatic drive_write(input int addr, input int vi, input int vq);
    PushCoef = 1'b1;
    CoefAddr = 5'(addr);
    CoefI    = 27'(vi);
    CoefQ    = 27'(vq);
    if (addr <= 14) begin
      sh_i[addr] = 27'(vi);
      sh_q[addr] = 27'(vq);
      dirty      = 1'b1;
    end
  endtask

  // Sample whose PH0 is issued in cycle c, using the current active bank.
  task automatic expect_sample(input int c);
    logic [NLANE*CW-1:0] li, lq;
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 5; k++) begin
        li[k*CW +: CW] = ac_i[p*5+k];
        lq[k*CW +: CW] = ac_q[p*5+k];
      end
      exp_issue.push_back('{c + p, 2'(p), li, lq});
    end
    exp_acc.push_back('{c + 4, 1'b1, 1'b0});
    exp_acc.push_back('{c + 5, 1'b0, 1'b1});
    exp_acc.push_back('{c + 6, 1'b0, 1'b1});
    exp_push.push_back(c + 7);
  endtask

  task automatic monitor();
    issue_t e;
    acc_t   a;
    logic   eld, een, epo;
    forever begin
      @(negedge Clk);
      if (mon_en) begin
        total++;
        if (exp_issue.size() > 0 && exp_issue[0].cyc == cyc) begin
          e = exp_issue.pop_front();
          if (Phase !== e.ph || FifoRd !== (e.ph == 2'd0) || ShiftEn !== (e.ph == 2'd0) ||
              CenterSel !== (e.ph == 2'd2) || LaneCoefI !== e.li || LaneCoefQ !== e.lq) begin
            bad++;
            $display("FAIL issue cyc=%0d: got ph=%0d rd=%b sh=%b ctr=%b I=%h Q=%h, want ph=%0d I=%h Q=%h",
                     cyc, Phase, FifoRd, ShiftEn, CenterSel, LaneCoefI, LaneCoefQ, e.ph, e.li, e.lq);
          end
        end else if (Phase !== 2'd3 || FifoRd !== 1'b0 || ShiftEn !== 1'b0 || CenterSel !== 1'b0 ||
                     LaneCoefI !== '0 || LaneCoefQ !== '0) begin
          bad++;
          $display("FAIL idle cyc=%0d: got ph=%0d rd=%b sh=%b ctr=%b I=%h Q=%h, want idle outputs",
                   cyc, Phase, FifoRd, ShiftEn, CenterSel, LaneCoefI, LaneCoefQ);
        end
        eld = 1'b0;
        een = 1'b0;
        if (exp_acc.size() > 0 && exp_acc[0].cyc == cyc) begin
          a   = exp_acc.pop_front();
          eld = a.ld;
          een = a.en;
        end
        total++;
        if ({AccLoad, AccEn} !== {eld, een}) begin
          bad++;
          $display("FAIL acc cyc=%0d: got load=%b en=%b, want load=%b en=%b", cyc, AccLoad, AccEn, eld, een);
        end
        epo = 1'b0;
        if (exp_push.size() > 0 && exp_push[0] == cyc) begin
          void'(exp_push.pop_front());
          epo = 1'b1;
        end
        total++;
        if (PushOut !== epo) begin
          bad++;
          $display("FAIL push cyc=%0d: got %b, want %b", cyc, PushOut, epo);
        end
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; FifoEmpty = 1'b1; PushCoef = 1'b0;
    CoefAddr = '0; CoefI = '0; CoefQ = '0;
    m_clear();
    tick();
    tick();
    total++;
    if (Phase !== 2'd3 || FifoRd !== 1'b0 || ShiftEn !== 1'b0 || CenterSel !== 1'b0 || AccLoad !== 1'b0 ||
        AccEn !== 1'b0 || PushOut !== 1'b0 || LaneCoefI !== '0 || LaneCoefQ !== '0) begin
      bad++;
      $display("FAIL reset_values: got ph=%0d rd=%b ld=%b en=%b po=%b, want ph=3 and all zero",
               Phase, FifoRd, AccLoad, AccEn, PushOut);
    end
    Reset  = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (Phase !== 2'd3 || FifoRd !== 1'b0 || AccEn !== 1'b0 || AccLoad !== 1'b0 || PushOut !== 1'b0) begin
        bad++;
        $display("FAIL idle_hold: got ph=%0d rd=%b ld=%b en=%b po=%b, want ph=3 rest 0",
                 Phase, FifoRd, AccLoad, AccEn, PushOut);
      end
    end
  endtask

  task automatic test_single_sample();
    int k, rd_cnt;
    for (int t = 0; t < 15; t++) begin
      drive_write(t, t + 1, -(t + 1));
      tick();
    end
    PushCoef = 1'b0; FifoEmpty = 1'b0;
    m_swap();
    k = cyc;
    expect_sample(k + 1);
    tick();
    FifoEmpty = 1'b1;
    rd_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (FifoRd === 1'b1) rd_cnt++;
      if (cyc == k + 1) begin
        total++;
        if (LaneCoefI[0 +: CW] !== 27'sd1 || LaneCoefQ[0 +: CW] !== -27'sd1) begin
          bad++;
          $display("FAIL ph0_lane0: got I=%0d Q=%0d, want I=1 Q=-1",
                   $signed(LaneCoefI[0 +: CW]), $signed(LaneCoefQ[0 +: CW]));
        end
      end
      if (cyc == k + 3) begin
        total++;
        if (LaneCoefI[4*CW +: CW] !== 27'sd15 || CenterSel !== 1'b1) begin
          bad++;
          $display("FAIL ph2_center: got I=%0d ctr=%b, want I=15 ctr=1",
                   $signed(LaneCoefI[4*CW +: CW]), CenterSel);
        end
      end
      tick();
    end
    total++;
    if (rd_cnt != 1) begin
      bad++;
      $display("FAIL single_fiford: got %0d pulses, want 1", rd_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int k, rd_cnt, idle_cnt;
    k = cyc;
    FifoEmpty = 1'b0;
    m_swap();
    for (int s = 0; s < 4; s++) expect_sample(k + 1 + 3*s);
    rd_cnt = 0;
    idle_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cyc == k + 10) FifoEmpty = 1'b1;
      if (FifoRd === 1'b1) rd_cnt++;
      if (cyc <= k + 12 && Phase === 2'd3) idle_cnt++;
    end
    total++;
    if (rd_cnt != 4 || idle_cnt != 0) begin
      bad++;
      $display("FAIL b2b: got fiford=%0d idle=%0d, want fiford=4 idle=0", rd_cnt, idle_cnt);
    end
  endtask

  task automatic test_coef_update();
    int k;
    k = cyc;
    FifoEmpty = 1'b0;
    m_swap();
    expect_sample(k + 1);
    tick();
    total++;
    if (LaneCoefI[3*CW +: CW] !== 27'sd4 || LaneCoefQ[3*CW +: CW] !== -27'sd4) begin
      bad++;
      $display("FAIL tap3_old: got I=%0d Q=%0d, want I=4 Q=-4",
               $signed(LaneCoefI[3*CW +: CW]), $signed(LaneCoefQ[3*CW +: CW]));
    end
    tick();
    drive_write(3, 100, 7);
    tick();
    PushCoef = 1'b0;
    m_swap();
    expect_sample(k + 4);
    tick();
    FifoEmpty = 1'b1;
    total++;
    if (LaneCoefI[3*CW +: CW] !== 27'sd100 || LaneCoefQ[3*CW +: CW] !== 27'sd7) begin
      bad++;
      $display("FAIL tap3_new: got I=%0d Q=%0d, want I=100 Q=7",
               $signed(LaneCoefI[3*CW +: CW]), $signed(LaneCoefQ[3*CW +: CW]));
    end
    repeat (10) tick();
  endtask

  task automatic test_bad_addr_boundary();
    int k;
    drive_write(20, 5, 99);
    tick();
    PushCoef = 1'b0;
    k = cyc;
    FifoEmpty = 1'b0;
    m_swap();
    expect_sample(k + 1);
    tick();
    FifoEmpty = 1'b1;
    total++;
    if (LaneCoefI[4*CW +: CW] !== 27'sd5 || LaneCoefQ[4*CW +: CW] !== -27'sd5) begin
      bad++;
      $display("FAIL bad_addr: got tap4 I=%0d Q=%0d, want I=5 Q=-5",
               $signed(LaneCoefI[4*CW +: CW]), $signed(LaneCoefQ[4*CW +: CW]));
    end
    repeat (8) tick();
    k = cyc;
    FifoEmpty = 1'b0;
    m_swap();
    expect_sample(k + 1);
    tick(); tick(); tick();
    m_swap();
    expect_sample(k + 4);
    drive_write(7, -50, 60);
    tick();
    PushCoef = 1'b0;
    tick();
    total++;
    if (LaneCoefI[2*CW +: CW] !== 27'sd8 || LaneCoefQ[2*CW +: CW] !== -27'sd8) begin
      bad++;
      $display("FAIL edge_write_same: got tap7 I=%0d Q=%0d, want I=8 Q=-8",
               $signed(LaneCoefI[2*CW +: CW]), $signed(LaneCoefQ[2*CW +: CW]));
    end
    tick();
    m_swap();
    expect_sample(k + 7);
    tick();
    FifoEmpty = 1'b1;
    tick();
    total++;
    if (LaneCoefI[2*CW +: CW] !== -27'sd50 || LaneCoefQ[2*CW +: CW] !== 27'sd60) begin
      bad++;
      $display("FAIL edge_write_next: got tap7 I=%0d Q=%0d, want I=-50 Q=60",
               $signed(LaneCoefI[2*CW +: CW]), $signed(LaneCoefQ[2*CW +: CW]));
    end
    repeat (10) tick();
  endtask

  task automatic test_reset_midflight();
    int k;
    k = cyc;
    FifoEmpty = 1'b0;
    m_swap();
    expect_sample(k + 1);
    expect_sample(k + 4);
    repeat (5) tick();
    Reset = 1'b1;
    exp_issue.delete();
    exp_acc.delete();
    exp_push.delete();
    m_clear();
    tick();
    Reset = 1'b0;
    FifoEmpty = 1'b1;
    total++;
    if (Phase !== 2'd3 || FifoRd !== 1'b0 || ShiftEn !== 1'b0 || CenterSel !== 1'b0 || AccLoad !== 1'b0 ||
        AccEn !== 1'b0 || PushOut !== 1'b0 || LaneCoefI !== '0 || LaneCoefQ !== '0) begin
      bad++;
      $display("FAIL midflight_reset: got ph=%0d rd=%b ld=%b en=%b po=%b, want ph=3 and all zero",
               Phase, FifoRd, AccLoad, AccEn, PushOut);
    end
    repeat (12) tick();
    k = cyc;
    FifoEmpty = 1'b0;
    m_swap();
    expect_sample(k + 1);
    tick();
    FifoEmpty = 1'b1;
    total++;
    if (Phase !== 2'd0 || LaneCoefI !== '0 || LaneCoefQ !== '0) begin
      bad++;
      $display("FAIL restart_lanes: got ph=%0d I=%h Q=%h, want ph=0 and zero lanes", Phase, LaneCoefI, LaneCoefQ);
    end
    repeat (10) tick();
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single_sample();
    test_back_to_back();
    test_coef_update();
    test_bad_addr_boundary();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
